// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver: 2-flop synchronised rx line, mid-bit
// sampling from an OVERSAMPLE x baud tick, one-cycle valid with parity/framing status.
module uart_rx_sipo #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_TYP = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 sample_tick,
   input  logic                 data_rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_flag,
   output logic                 active_flag,
   output logic                 parity_err,
   output logic                 frame_err
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int IDX_W  = $clog2(DATA_BITS + 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);
   localparam logic              PAR_ODD   = (PARITY_TYP != 0);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           sync_q;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 valid_q, valid_d;
   logic                 active_q, active_d;

   logic rxs;
   logic at_mid;
   logic at_end;

   assign rxs    = sync_q[1];
   assign at_mid = sample_tick && (tick_cnt_q == TICK_MID);
   assign at_end = sample_tick && (tick_cnt_q == TICK_END);

   // State register; the synchroniser resets to the idle-high line level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sync_q  <= 2'b11;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         sync_q  <= {sync_q[0], data_rx};
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (sample_tick && !rxs) state_d = ST_START;
         ST_START:  if (at_mid) state_d = rxs ? ST_IDLE : ST_DATA;
         ST_DATA:   if (at_end && bit_idx_q == LAST_DATA)
                       state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (at_end) state_d = ST_STOP;
         ST_STOP:   if (at_end && bit_idx_q == LAST_STOP)
                       state_d = (ferr_q || !rxs) ? ST_BREAK : ST_IDLE;
         ST_BREAK:  if (sample_tick && rxs) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next-values.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      data_d     = data_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      valid_d    = 1'b0;
      active_d   = (state_d != ST_IDLE);

      if (state_d != state_q) begin
         tick_cnt_d = '0;
         bit_idx_d  = '0;
      end else if (sample_tick) begin
         tick_cnt_d = (tick_cnt_q == TICK_END) ? '0 : tick_cnt_q + TICK_W'(1);
      end

      // A new frame starts with clean per-frame status.
      if (state_q == ST_IDLE && state_d == ST_START) begin
         shift_d = '0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
      end

      if (at_end) begin
         unique case (state_q)
            ST_DATA: begin
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (state_d == state_q) bit_idx_d = bit_idx_q + IDX_W'(1);
            end
            ST_PARITY: perr_d = rxs ^ (^shift_q) ^ PAR_ODD;
            ST_STOP: begin
               ferr_d = ferr_q | ~rxs;
               if (bit_idx_q == LAST_STOP) begin
                  data_d     = shift_q;
                  perr_out_d = perr_q;
                  ferr_out_d = ferr_q | ~rxs;
                  valid_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         valid_q    <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         data_q     <= data_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         valid_q    <= valid_d;
         active_q   <= active_d;
      end
   end

   assign data_out    = data_q;
   assign valid_flag  = valid_q;
   assign active_flag = active_q;
   assign parity_err  = perr_out_q;
   assign frame_err   = ferr_out_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo (8E1, 16x oversample) with a bench-side
// serialiser standing in for the TX PISO; one sample_tick every 4 clocks.
module tb_uart_rx_sipo;

   localparam int OS      = 16;
   localparam int TICK_CK = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       sample_tick = 1'b0;
   logic       data_rx = 1'b1;
   logic [7:0] data_out;
   logic       valid_flag, active_flag, parity_err, frame_err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clock = ~clock;

   uart_rx_sipo #(
      .DATA_BITS(8), .PARITY_EN(1), .PARITY_TYP(0), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) dut (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .data_rx(data_rx),
      .data_out(data_out), .valid_flag(valid_flag), .active_flag(active_flag),
      .parity_err(parity_err), .frame_err(frame_err)
   );

   // Monitor: logs every valid pulse with its cycle number and status.
   int unsigned cyc = 0, vcnt = 0, run = 0, max_run = 0, act_cyc = 0;
   logic [7:0]  vdata[$];
   int unsigned vcyc[$];
   logic [1:0]  verr[$];

   always @(posedge clock) begin
      cyc++;
      if (active_flag) act_cyc++;
      if (valid_flag) begin
         vcnt++;
         run++;
         vdata.push_back(data_out);
         vcyc.push_back(cyc);
         verr.push_back({parity_err, frame_err});
      end else begin
         run = 0;
      end
      if (run > max_run) max_run = run;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock) sample_tick = 1'b1;
         @(negedge clock) sample_tick = 1'b0;
         repeat (TICK_CK - 2) @(negedge clock);
      end
   endtask

   task automatic send_bit(input logic b);
      data_rx = b;
      tick_n(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   initial begin
      int unsigned v0, n0, a0;
      logic [7:0] lb [4];

      // Reset state
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_data", data_out, 8'h00);
      check("rst_valid", valid_flag, 1'b0);
      check("rst_active", active_flag, 1'b0);
      check("rst_perr", parity_err, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      reset_n = 1'b1;
      tick_n(4);

      // Basic 0xA5, even parity 0, stop 1
      v0 = vcnt;
      send_frame(8'hA5, 1'b0, 1'b1);
      tick_n(4);
      check("basic_vcnt", vcnt - v0, 1);
      check("basic_data", data_out, 8'hA5);
      check("basic_perr", parity_err, 1'b0);
      check("basic_ferr", frame_err, 1'b0);
      check("basic_active", active_flag, 1'b0);

      // Parity error
      v0 = vcnt;
      send_frame(8'hA5, 1'b1, 1'b1);
      tick_n(4);
      check("par_vcnt", vcnt - v0, 1);
      check("par_data", data_out, 8'hA5);
      check("par_perr", parity_err, 1'b1);
      check("par_ferr", frame_err, 1'b0);

      // Frame error followed by a 40-bit break
      v0 = vcnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      data_rx = 1'b0;
      tick_n(40 * OS);
      check("brk_vcnt", vcnt - v0, 1);
      check("brk_data", data_out, 8'h3C);
      check("brk_ferr", frame_err, 1'b1);
      check("brk_perr", parity_err, 1'b0);
      check("brk_active_low", active_flag, 1'b1);
      data_rx = 1'b1;
      repeat (3) @(negedge clock);
      check("brk_active_pre_tick", active_flag, 1'b1);
      tick_n(1);
      check("brk_active_post_tick", active_flag, 1'b0);
      check("brk_vcnt_end", vcnt - v0, 1);
      tick_n(8);

      // Glitch: 4 ticks low then high
      v0 = vcnt;
      a0 = act_cyc;
      data_rx = 1'b0;
      tick_n(4);
      data_rx = 1'b1;
      tick_n(8);
      check("glitch_saw_active", act_cyc != a0, 1'b1);
      check("glitch_active", active_flag, 1'b0);
      check("glitch_vcnt", vcnt - v0, 0);

      // Back-to-back 0x3C, 0xC3: 11 bit periods apart
      n0 = vdata.size();
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b1);
      tick_n(4);
      check("b2b_count", vdata.size() - n0, 2);
      if (vdata.size() >= n0 + 2) begin
         check("b2b_data0", vdata[n0], 8'h3C);
         check("b2b_data1", vdata[n0+1], 8'hC3);
         check("b2b_err0", verr[n0], 2'b00);
         check("b2b_err1", verr[n0+1], 2'b00);
         check("b2b_gap", vcyc[n0+1] - vcyc[n0], 11 * OS * TICK_CK);
      end

      // Reset during second frame's data bits
      v0 = vcnt;
      send_frame(8'h3C, 1'b0, 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
      reset_n = 1'b0;
      #1;
      check("mid_rst_vcnt", vcnt - v0, 1);
      check("mid_rst_data", data_out, 8'h00);
      check("mid_rst_valid", valid_flag, 1'b0);
      check("mid_rst_active", active_flag, 1'b0);
      check("mid_rst_perr", parity_err, 1'b0);
      check("mid_rst_ferr", frame_err, 1'b0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      data_rx = 1'b1;
      tick_n(12 * OS);
      check("mid_rst_no_valid", vcnt - v0, 1);
      check("mid_rst_data_hold", data_out, 8'h00);

      // Serialiser loopback, back-to-back bytes with computed even parity
      lb = '{8'h00, 8'hFF, 8'h55, 8'hA5};
      n0 = vdata.size();
      for (int k = 0; k < 4; k++) send_frame(lb[k], ^lb[k], 1'b1);
      tick_n(4);
      check("loop_count", vdata.size() - n0, 4);
      if (vdata.size() >= n0 + 4) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("loop_data%0d", k), vdata[n0+k], lb[k]);
            check($sformatf("loop_err%0d", k), verr[n0+k], 2'b00);
         end
      end

      check("valid_width", max_run, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Serial-in/parallel-out UART receiver. It is the receive-side counterpart of the existing TX PISO and uses the same frame format parameters. It oversamples the asynchronous rx line with a 16x baud tick, synchronises and mid-bit samples it, then presents the assembled word with a one-cycle valid strobe plus parity and framing status. It sits between the pad-side serial input and the core's RX buffer/FIFO.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB transmitted first
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit
PARITY_TYP, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=8)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  single-cycle strobe at OVERSAMPLE x baud rate
data_rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  last received word, held until next frame completes
valid_flag  output  1  one-cycle pulse: data_out/parity_err/frame_err updated
active_flag  output  1  high while a frame is in progress (state != IDLE)
parity_err  output  1  parity mismatch on last frame, held with data_out
frame_err  output  1  a stop bit sampled 0 on last frame, held with data_out

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; synchroniser flops=1; data_out=0; valid_flag, active_flag, parity_err, frame_err=0; tick counter, bit index, and shift register cleared. Reset asserted mid-frame aborts the frame with no valid_flag.
- Input path: two-flop synchroniser on data_rx; all decisions use the synchronised bit rxs (2-clock input latency).
- Counters and ticks: tick_cnt is log2(OVERSAMPLE) bits wide. It advances only on sample_tick. It clears on every state change.
- IDLE: on sample_tick with rxs=0, go to START.
- START: on the tick where tick_cnt=OVERSAMPLE/2-1 (mid start bit), re-sample rxs.
  - rxs=1: glitch; return to IDLE with no flags.
  - rxs=0: go to DATA with bit_idx=0.
- DATA: on the tick where tick_cnt=OVERSAMPLE-1 (mid-bit), shift rxs into the shift register LSB-first and increment bit_idx. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: sample at tick_cnt=OVERSAMPLE-1.
  - Computed parity = XOR of data bits, XOR PARITY_TYP.
  - Mismatch sets the internal parity error. Then go to STOP.
- STOP: sample each stop bit at tick_cnt=OVERSAMPLE-1. Any stop sample of 0 sets the internal frame error. On the sample of the last stop bit:
  - Register data_out, parity_err and frame_err.
  - Pulse valid_flag on the next clock, for exactly one cycle.
  - Go to IDLE if no frame error, else go to BREAK_WAIT.
- BREAK_WAIT: stay until rxs=1 is seen on a sample_tick, then go to IDLE. This stops a held-low (break) line from being decoded as a stream of 0x00 frames.
- active_flag = (state != IDLE), registered.
- Latency: valid_flag rises 1 clock after the sample_tick that samples the midpoint of the last stop bit.
- Back-to-back frames: a start edge that arrives right after the last stop sample is accepted. The IDLE start detection is effectively re-armed in the same cycle valid_flag is issued.
- Status hold: valid_flag is not held or acknowledged. Status outputs hold until the next completed frame, which overwrites them (no sticky accumulation).
- sample_tick outside a frame has no effect except the IDLE start check.

Test Plan:
- Basic frame: OVERSAMPLE=16, 8E1. Send 0xA5 with parity 0 and stop 1, at 16 ticks per bit. Required: one valid_flag pulse, data_out=0xA5, parity_err=0, frame_err=0, active_flag low afterwards.
- Parity error: send 0xA5 with parity bit 1. Required: valid_flag pulse, data_out=0xA5, parity_err=1, frame_err=0.
- Frame error and break: send 0x3C with stop bit 0, then hold the line low for 40 bit times. Required: exactly one valid_flag, frame_err=1, active_flag stays high. No further valid until the line returns high; active_flag drops on the first high tick.
- Glitch rejection: drive data_rx low for 4 ticks, then high. Required: active_flag rises then returns low within 8 ticks; no valid_flag.
- Back-to-back: send 0x3C then 0xC3 with no idle gap. Required: two valid_flag pulses 11 bit periods apart, with data_out 0x3C then 0xC3 and no errors. Also assert reset_n low during the second frame's data bits: no second valid, and all outputs read 0.
- Loopback: connect uart_tx_piso data_tx to data_rx, with TX baud_tick = sample_tick/16 and the same parameters. Send 0x00, 0xFF, 0x55, 0xA5. Required: each byte received exactly, with no errors.
